// File: rtl/dvi_stream_capture.sv
// Pixel-clocked DVI capture into an AXI4-Stream video master (tuser = SOF, tlast = EOL).
// Optional build macro DVI_CAPTURE_DECIMATE_EN adds the `decimate` input (keep even pixels only).
module dvi_stream_capture #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             m_axis_vid_aclk,
  input  logic             aresetn,
  input  logic             vid_hsync,
  input  logic             vid_vsync,
  input  logic             vid_active,
  input  logic [23:0]      vid_rgb,
  input  logic             enable,
  input  logic             sync_polarity,
`ifdef DVI_CAPTURE_DECIMATE_EN
  input  logic             decimate,
`endif
  input  logic [CNT_W-1:0] capture_width,
  input  logic [CNT_W-1:0] capture_height,
  output logic [31:0]      m_axis_vid_tdata,
  output logic             m_axis_vid_tvalid,
  input  logic             m_axis_vid_tready,
  output logic             m_axis_vid_tlast,
  output logic             m_axis_vid_tuser,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] NEAR_CNT  = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE, DROP} state_t;
  state_t state, state_nxt;

  logic             vs, vs_q, vs_q2, frame_start;
  logic             hs_unused;
  logic             p_act;
  logic [23:0]      p_rgb;
  logic [CNT_W-1:0] width_q, height_q, x, y;
  logic             sof;
  logic             keep, take, push, pop, last_w, ovf_evt;
  logic             near_full, full_eff;
  logic [AW:0]      count, cnt_eff;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [25:0]      mem [FIFO_DEPTH];
  logic [25:0]      rd_word;

  assign vs          = vid_vsync ^ sync_polarity;
  assign frame_start = vs_q & ~vs_q2;
  // Line boundaries come from vid_active; hsync is only observed.
  assign hs_unused   = vid_hsync ^ sync_polarity;

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
      p_act <= 1'b0;
      p_rgb <= '0;
    end else begin
      vs_q  <= vs;
      vs_q2 <= vs_q;
      p_act <= vid_active;
      p_rgb <= vid_rgb;
    end
  end

`ifdef DVI_CAPTURE_DECIMATE_EN
  logic dec_q, p_odd;
  // Pixel phase within the current active run; first pixel of a run is even.
  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      p_odd <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      p_odd <= vid_active & p_act & ~p_odd;
      if (frame_start) dec_q <= decimate;
    end
  end
  assign keep = ~dec_q | ~p_odd;
`else
  assign keep = 1'b1;
`endif

  // State register
  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = IDLE;
      WAIT_LINE: if (vid_active && !p_act) state_nxt = LINE;
      LINE: begin
        if (ovf_evt)
          state_nxt = DROP;
        else if (push && last_w)
          state_nxt = (y == height_q - CNT_W'(1)) ? IDLE : WAIT_LINE;
      end
      DROP:      state_nxt = DROP;
      default:   state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = enable ? WAIT_LINE : IDLE;
  end

  // Output / datapath control
  always_comb begin
    pop       = m_axis_vid_tvalid & m_axis_vid_tready;
    cnt_eff   = count - (AW+1)'(pop);
    near_full = (cnt_eff == NEAR_CNT);
    full_eff  = (cnt_eff == FULL_CNT);
    take      = (state == LINE) & p_act & keep;
    push      = take & ~full_eff;
    ovf_evt   = take & (near_full | full_eff);
    // A frame start or near-full FIFO closes the line on the pixel being stored.
    last_w    = (x == width_q - CNT_W'(1)) | ~vid_active | frame_start | near_full;
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      width_q  <= '0;
      height_q <= '0;
      x        <= '0;
      y        <= '0;
      sof      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state != LINE) x <= '0;
      else if (push)     x <= x + CNT_W'(1);

      if (frame_start) begin
        width_q  <= capture_width;
        height_q <= capture_height;
        y        <= '0;
        sof      <= enable;
      end else if (push) begin
        sof <= 1'b0;
        if (last_w) y <= y + CNT_W'(1);
      end

      if (ovf_evt) overflow <= 1'b1;
    end
  end

  // First-word fall-through FIFO of {tuser, tlast, rgb}
  always_ff @(posedge m_axis_vid_aclk) begin
    if (push) mem[wr_ptr] <= {sof, last_w, p_rgb};
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rd_word           = mem[rd_ptr];
  assign m_axis_vid_tvalid = (count != '0);
  assign m_axis_vid_tdata  = m_axis_vid_tvalid ? {8'h00, rd_word[23:0]} : '0;
  assign m_axis_vid_tlast  = m_axis_vid_tvalid & rd_word[24];
  assign m_axis_vid_tuser  = m_axis_vid_tvalid & rd_word[25];

endmodule

// File: tb/tb_dvi_stream_capture.sv
// Directed self-checking bench for dvi_stream_capture (FIFO_DEPTH=8).
module tb_dvi_stream_capture;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 12;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          vid_hsync = 1'b0, vid_vsync = 1'b0, vid_active = 1'b0;
  logic [23:0]   vid_rgb = '0;
  logic          enable = 1'b0, sync_polarity = 1'b0;
  logic [CW-1:0] capture_width = '0, capture_height = '0;
  logic [31:0]   tdata;
  logic          tvalid, tlast, tuser, overflow;
  logic          tready = 1'b1;
`ifdef DVI_CAPTURE_DECIMATE_EN
  logic          decimate = 1'b0;
`endif

  always #5 clk = ~clk;

  dvi_stream_capture #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .m_axis_vid_aclk   (clk),
    .aresetn           (aresetn),
    .vid_hsync         (vid_hsync),
    .vid_vsync         (vid_vsync),
    .vid_active        (vid_active),
    .vid_rgb           (vid_rgb),
    .enable            (enable),
    .sync_polarity     (sync_polarity),
`ifdef DVI_CAPTURE_DECIMATE_EN
    .decimate          (decimate),
`endif
    .capture_width     (capture_width),
    .capture_height    (capture_height),
    .m_axis_vid_tdata  (tdata),
    .m_axis_vid_tvalid (tvalid),
    .m_axis_vid_tready (tready),
    .m_axis_vid_tlast  (tlast),
    .m_axis_vid_tuser  (tuser),
    .overflow          (overflow)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_valid = -1;
  int drive_start = 0;
  int stall_viol = 0;
  bit tog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;
  logic [31:0] bd[$];
  logic        bl[$];
  logic        bu[$];

  always @(posedge clk) cyc++;

  // Beat recorder and stall-stability observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tvalid || {tuser, tlast, tdata} !== prev_out)) stall_viol++;
      prev_stall = tvalid && !tready;
      prev_out   = {tuser, tlast, tdata};
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (tvalid && tready) begin
        bd.push_back(tdata);
        bl.push_back(tlast);
        bu.push_back(tuser);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tog) tready = ~tready;
    end
  endtask

  task automatic clear_mon();
    bd.delete(); bl.delete(); bu.delete();
    first_valid = -1;
    stall_viol  = 0;
  endtask

  task automatic do_reset();
    aresetn    = 1'b0;
    vid_active = 1'b0;
    vid_rgb    = '0;
    vid_hsync  = sync_polarity;
    vid_vsync  = sync_polarity;
    enable     = 1'b0;
    tready     = 1'b1;
    tog        = 1'b0;
`ifdef DVI_CAPTURE_DECIMATE_EN
    decimate   = 1'b0;
`endif
    tick(3);
    aresetn = 1'b1;
    tick(2);
    clear_mon();
  endtask

  task automatic frame_sync();
    vid_vsync = ~sync_polarity;
    tick(3);
    vid_vsync = sync_polarity;
    tick(3);
  endtask

  task automatic send_run(input int n, input logic [7:0] tag, input logic [7:0] ln);
    for (int i = 0; i < n; i++) begin
      vid_active = 1'b1;
      vid_rgb    = {tag, ln, 8'(i)};
      if (i == 0) drive_start = cyc;
      tick(1);
    end
    vid_active = 1'b0;
    vid_rgb    = '0;
    tick(4);
  endtask

  task automatic test_reset();
    sync_polarity = 1'b0;
    do_reset();
    checks++; if (tvalid !== 1'b0)  begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid); end
    checks++; if (tdata !== 32'h0)  begin errors++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    checks++; if (tlast !== 1'b0)   begin errors++; $display("FAIL reset_tlast got=%0b exp=0", tlast); end
    checks++; if (tuser !== 1'b0)   begin errors++; $display("FAIL reset_tuser got=%0b exp=0", tuser); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_stream();
    capture_width = 12'd4; capture_height = 12'd2; enable = 1'b1; tready = 1'b1;
    frame_sync();
    clear_mon();
    send_run(4, 8'hA1, 8'd0);
    checks++; if (first_valid - drive_start != 2)
      begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_valid - drive_start); end
    send_run(4, 8'hA1, 8'd1);
    tick(6);
    checks++; if (bd.size() != 8) begin errors++; $display("FAIL stream_beats got=%0d exp=8", bd.size()); end
    for (int k = 0; k < bd.size() && k < 8; k++) begin
      checks++; if (bd[k] !== {8'h00, 8'hA1, 8'(k / 4), 8'(k % 4)})
        begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, bd[k], {8'h00, 8'hA1, 8'(k / 4), 8'(k % 4)}); end
      checks++; if (bl[k] !== (k % 4 == 3)) begin errors++; $display("FAIL stream_tlast[%0d] got=%0b exp=%0b", k, bl[k], (k % 4 == 3)); end
      checks++; if (bu[k] !== (k == 0))     begin errors++; $display("FAIL stream_tuser[%0d] got=%0b exp=%0b", k, bu[k], (k == 0)); end
    end
    // Frame complete after two lines: a further line must be ignored.
    send_run(4, 8'hA1, 8'd2);
    tick(4);
    checks++; if (bd.size() != 8) begin errors++; $display("FAIL stream_after_frame got=%0d exp=8", bd.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_backpressure();
    tready = 1'b1;
    frame_sync();
    clear_mon();
    tog = 1'b1;
    send_run(4, 8'hA1, 8'd0);
    send_run(4, 8'hA1, 8'd1);
    tick(30);
    tog = 1'b0; tready = 1'b1;
    tick(2);
    checks++; if (bd.size() != 8) begin errors++; $display("FAIL bp_beats got=%0d exp=8", bd.size()); end
    for (int k = 0; k < bd.size() && k < 8; k++) begin
      checks++; if (bd[k] !== {8'h00, 8'hA1, 8'(k / 4), 8'(k % 4)} || bl[k] !== (k % 4 == 3) || bu[k] !== (k == 0))
        begin errors++; $display("FAIL bp_beat[%0d] got=%h/%0b/%0b exp=%h/%0b/%0b", k, bd[k], bl[k], bu[k],
                                 {8'h00, 8'hA1, 8'(k / 4), 8'(k % 4)}, (k % 4 == 3), (k == 0)); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
  endtask

  task automatic test_overflow();
    sync_polarity = 1'b0;
    do_reset();
    capture_width = 12'd12; capture_height = 12'd1; enable = 1'b1; tready = 1'b0;
    frame_sync();
    send_run(12, 8'hC3, 8'd0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (bd.size() != 0)    begin errors++; $display("FAIL ovf_no_beats_stalled got=%0d exp=0", bd.size()); end
    tready = 1'b1;
    tick(15);
    checks++; if (bd.size() != 8) begin errors++; $display("FAIL ovf_beats got=%0d exp=8", bd.size()); end
    for (int k = 0; k < bd.size() && k < 8; k++) begin
      checks++; if (bd[k] !== {8'h00, 8'hC3, 8'h00, 8'(k)}) begin errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", k, bd[k], {8'h00, 8'hC3, 8'h00, 8'(k)}); end
      checks++; if (bl[k] !== (k == 7)) begin errors++; $display("FAIL ovf_tlast[%0d] got=%0b exp=%0b", k, bl[k], (k == 7)); end
    end
    clear_mon();
    capture_width = 12'd4;
    frame_sync();
    send_run(4, 8'hC4, 8'd0);
    tick(6);
    checks++; if (bd.size() != 4) begin errors++; $display("FAIL ovf_resync_beats got=%0d exp=4", bd.size()); end
    if (bd.size() == 4) begin
      checks++; if (bu[0] !== 1'b1 || bl[3] !== 1'b1 || bd[3] !== 32'h00C4_0003)
        begin errors++; $display("FAIL ovf_resync_frame got=%0b/%0b/%h exp=1/1/00c40003", bu[0], bl[3], bd[3]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_width_truncation();
    sync_polarity = 1'b0;
    do_reset();
    capture_width = 12'd8; capture_height = 12'd2; enable = 1'b1;
    frame_sync();
    send_run(5, 8'hD0, 8'd0);
    send_run(10, 8'hD0, 8'd1);
    tick(6);
    checks++; if (bd.size() != 13) begin errors++; $display("FAIL trunc_beats got=%0d exp=13", bd.size()); end
    for (int k = 0; k < bd.size() && k < 13; k++) begin
      logic [7:0] ln, ix;
      ln = (k < 5) ? 8'd0 : 8'd1;
      ix = (k < 5) ? 8'(k) : 8'(k - 5);
      checks++; if (bd[k] !== {8'h00, 8'hD0, ln, ix}) begin errors++; $display("FAIL trunc_data[%0d] got=%h exp=%h", k, bd[k], {8'h00, 8'hD0, ln, ix}); end
      checks++; if (bl[k] !== (k == 4 || k == 12)) begin errors++; $display("FAIL trunc_tlast[%0d] got=%0b exp=%0b", k, bl[k], (k == 4 || k == 12)); end
      checks++; if (bu[k] !== (k == 0)) begin errors++; $display("FAIL trunc_tuser[%0d] got=%0b exp=%0b", k, bu[k], (k == 0)); end
    end
  endtask

  task automatic test_polarity_enable();
    sync_polarity = 1'b1;
    do_reset();
    capture_width = 12'd4; capture_height = 12'd1; enable = 1'b0;
    frame_sync();
    send_run(4, 8'hE0, 8'd0);
    tick(4);
    checks++; if (bd.size() != 0) begin errors++; $display("FAIL pol_disabled_beats got=%0d exp=0", bd.size()); end
    enable = 1'b1;
    frame_sync();
    send_run(4, 8'hE0, 8'd1);
    tick(6);
    checks++; if (bd.size() != 4) begin errors++; $display("FAIL pol_enabled_beats got=%0d exp=4", bd.size()); end
    for (int k = 0; k < bd.size() && k < 4; k++) begin
      checks++; if (bd[k] !== {8'h00, 8'hE0, 8'd1, 8'(k)} || bl[k] !== (k == 3) || bu[k] !== (k == 0))
        begin errors++; $display("FAIL pol_beat[%0d] got=%h/%0b/%0b exp=%h/%0b/%0b", k, bd[k], bl[k], bu[k],
                                 {8'h00, 8'hE0, 8'd1, 8'(k)}, (k == 3), (k == 0)); end
    end
    sync_polarity = 1'b0;
  endtask

  task automatic test_reset_midline();
    sync_polarity = 1'b0;
    do_reset();
    capture_width = 12'd8; capture_height = 12'd1; enable = 1'b1; tready = 1'b0;
    frame_sync();
    for (int i = 0; i < 5; i++) begin
      vid_active = 1'b1;
      vid_rgb    = {8'hF0, 8'h00, 8'(i)};
      tick(1);
    end
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre_tvalid got=%0b exp=1", tvalid); end
    aresetn = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%0b exp=0", tvalid); end
    checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL midrst_tdata got=%h exp=0", tdata); end
    tick(2);
    aresetn = 1'b1;
    tready  = 1'b1;
    clear_mon();
    tick(3);
    vid_active = 1'b0;
    tick(3);
    send_run(4, 8'hF0, 8'd1);
    tick(4);
    checks++; if (bd.size() != 0) begin errors++; $display("FAIL midrst_no_beats got=%0d exp=0", bd.size()); end
    capture_width = 12'd4;
    frame_sync();
    send_run(4, 8'hF1, 8'd0);
    tick(6);
    checks++; if (bd.size() != 4) begin errors++; $display("FAIL midrst_next_frame got=%0d exp=4", bd.size()); end
    if (bd.size() == 4) begin
      checks++; if (bu[0] !== 1'b1 || bd[0] !== 32'h00F1_0000 || bl[3] !== 1'b1)
        begin errors++; $display("FAIL midrst_frame got=%0b/%h/%0b exp=1/00f10000/1", bu[0], bd[0], bl[3]); end
    end
  endtask

`ifdef DVI_CAPTURE_DECIMATE_EN
  task automatic test_decimate();
    sync_polarity = 1'b0;
    do_reset();
    capture_width = 12'd4; capture_height = 12'd1; enable = 1'b1; decimate = 1'b1;
    frame_sync();
    send_run(8, 8'h90, 8'd0);
    tick(6);
    checks++; if (bd.size() != 4) begin errors++; $display("FAIL dec_beats got=%0d exp=4", bd.size()); end
    for (int k = 0; k < bd.size() && k < 4; k++) begin
      checks++; if (bd[k] !== {8'h00, 8'h90, 8'h00, 8'(2 * k)} || bl[k] !== (k == 3) || bu[k] !== (k == 0))
        begin errors++; $display("FAIL dec_beat[%0d] got=%h/%0b/%0b exp=%h/%0b/%0b", k, bd[k], bl[k], bu[k],
                                 {8'h00, 8'h90, 8'h00, 8'(2 * k)}, (k == 3), (k == 0)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_width_truncation();
    test_polarity_enable();
    test_reset_midline();
`ifdef DVI_CAPTURE_DECIMATE_EN
    test_decimate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
